// File: rtl/mem_stage_pkg.sv
// Shared types and opcode constants for the memory-access stage.
// Also holds the write-back destination decode used by mem_stage.
package mem_stage_pkg;

  localparam logic [5:0] OpRForm = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnJalr  = 6'h09;

  localparam logic [4:0] RegLink = 5'd31;

  typedef enum logic [0:0] {
    StIdle     = 1'b0,
    StLoadWait = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } wb_t;

  // Destination/enable for a non-faulting instruction. For LW the data field is
  // unused; the real value comes from the RAM one cycle later.
  function automatic wb_t wb_decode(input logic [5:0]  op,
                                    input logic [5:0]  funct,
                                    input logic [4:0]  rt,
                                    input logic [4:0]  rd,
                                    input logic [31:0] result,
                                    input logic [31:0] next_pc);
    wb_t wb;
    wb.wen   = 1'b0;
    wb.wreg  = 5'd0;
    wb.wdata = result;
    case (op)
      OpRForm: begin
        if (funct != FnJr) begin
          wb.wen  = 1'b1;
          wb.wreg = rd;
          if (funct == FnJalr) wb.wdata = next_pc;
        end
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpLw: begin
        wb.wen  = 1'b1;
        wb.wreg = rt;
      end
      OpJal: begin
        wb.wen   = 1'b1;
        wb.wreg  = RegLink;
        wb.wdata = next_pc;
      end
      default: ;
    endcase
    if (wb.wreg == 5'd0) wb.wen = 1'b0;
    return wb;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute -> memory stage -> write-back bundle.
// master is the upstream/driving side, slave is the memory stage.
interface mem_stage_if;

  logic        valid_in;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic [31:0] nextPC;
  logic        stall;
  logic        valid_out;
  logic        Wen;
  logic [4:0]  Wreg;
  logic [31:0] Wdata;
  logic        misalign;

  modport master (
    output valid_in, Ins, Result, Rdata2, nextPC,
    input  stall, valid_out, Wen, Wreg, Wdata, misalign
  );

  modport slave (
    input  valid_in, Ins, Result, Rdata2, nextPC,
    output stall, valid_out, Wen, Wreg, Wdata, misalign
  );

endinterface

// File: rtl/mem_stage_data_ram.sv
// Single-port word RAM: synchronous write, registered read, contents never reset.
module mem_stage_data_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: LW/SW against the local data RAM, registered write-back fields.
// Loads spend one extra cycle in StLoadWait, during which upstream is stalled.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input logic        CLK,
  input logic        RST,
  mem_stage_if.slave bus
);

  mem_state_e  state_q, state_d;
  logic        valid_out_q, valid_out_d;
  logic        wen_q, wen_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        misalign_q, misalign_d;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_lw, is_sw, aligned, accept;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;
  wb_t         wb;

  assign op      = bus.Ins[31:26];
  assign funct   = bus.Ins[5:0];
  assign is_lw   = (op == OpLw);
  assign is_sw   = (op == OpSw);
  assign aligned = (bus.Result[1:0] == 2'b00);
  assign accept  = (state_q == StIdle) && bus.valid_in;

  // Misaligned accesses never touch the RAM.
  assign ram_we = accept && is_sw && aligned;
  assign ram_re = accept && is_lw && aligned;

  assign wb = wb_decode(op, funct, bus.Ins[20:16], bus.Ins[15:11], bus.Result, bus.nextPC);

  mem_stage_data_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_data_ram (
    .clk_i   (CLK),
    .addr_i  (bus.Result[ADDR_W+1:2]),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .wdata_i (bus.Rdata2),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    valid_out_d = 1'b0;
    wen_d       = 1'b0;
    misalign_d  = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          if ((is_lw || is_sw) && !aligned) begin
            valid_out_d = 1'b1;
            misalign_d  = 1'b1;
          end else if (is_lw) begin
            state_d = StLoadWait;
            wreg_d  = wb.wreg;
          end else begin
            valid_out_d = 1'b1;
            wen_d       = wb.wen;
            wreg_d      = wb.wreg;
            wdata_d     = wb.wdata;
          end
        end
      end
      StLoadWait: begin
        // Inputs are ignored here; the registered RAM output is now valid.
        state_d     = StIdle;
        valid_out_d = 1'b1;
        wen_d       = (wreg_q != 5'd0);
        wdata_d     = ram_rdata;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      valid_out_q <= 1'b0;
      wen_q       <= 1'b0;
      wreg_q      <= 5'd0;
      wdata_q     <= 32'd0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_out_q <= valid_out_d;
      wen_q       <= wen_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.stall     = (state_q == StLoadWait);
  assign bus.valid_out = valid_out_q;
  assign bus.Wen       = wen_q;
  assign bus.Wreg      = wreg_q;
  assign bus.Wdata     = wdata_q;
  assign bus.misalign  = misalign_q;

  // Address bits above the RAM index wrap; rs and shamt are not needed here.
  logic unused_bits;
  assign unused_bits = ^{bus.Ins[25:21], bus.Ins[10:6], bus.Result[31:ADDR_W+2]};

endmodule
